data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory responder for the memory-access stage of the RISC-V pipeline. Accepts one load/store request at a time over a valid/ready request channel and performs the byte/half/word access on an internal word-organised array. It returns load data (sign- or zero-extended) or a store acknowledge over a valid/ready response channel. Configurable wait states model slow memory and let the pipeline exercise stall paths.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array
WAIT_STATES, 1, extra cycles between request acceptance and array access (0 allowed)
ADDR_BASE, 32'h0000_0000, byte address mapped to word index 0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  access faulted; no array write occurred

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/size/unsigned. Next state is WAIT (counter=WAIT_STATES) if WAIT_STATES>0, else ACCESS.
- WAIT: req_ready=0. Counter decrements each cycle; move to ACCESS on the edge where the counter reaches 0. WAIT lasts exactly WAIT_STATES cycles.
- ACCESS: single cycle. At the closing edge: perform the array read-modify-write or read, load rsp_rdata/rsp_err, go to RESP.
- Latency: rsp_valid rises WAIT_STATES+1 edges after the acceptance edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1; on that edge go to IDLE and clear rsp_valid.
- No request is accepted in the same cycle a response retires. Maximum throughput is one request per WAIT_STATES+3 cycles.
- Word index = (addr-ADDR_BASE)>>2, computed with 32-bit unsigned wrap.
  - Index >= DEPTH_WORDS: rsp_err=1, no write, rsp_rdata=0.
  - addr below ADDR_BASE wraps to a huge index and therefore errs.
- req_size=11: rsp_err=1, no write.
- Store byte: writes wdata[7:0] into lane addr[1:0]. Other lanes are unchanged.
- Store half: writes wdata[15:0] into lanes {addr[1],0}..{addr[1],1}.
- Store word: writes the full word.
- Store response: rsp_rdata=0, rsp_err=0.
- Load: selects the lane(s) using the same lane rules as stores, then extends per req_unsigned. Word loads ignore req_unsigned.
- Reset mid-operation: any state returns to IDLE immediately. A pending ACCESS write does not occur if rst is asserted before its edge. Array content is otherwise retained.
- Request inputs are ignored outside IDLE.

Optional Feature:
Macro DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, gives rsp_err=1, no write, rsp_rdata=0, with normal latency.
- Undefined: offending low address bits are forced to zero (half: addr[0]; word: addr[1:0]). The access proceeds at the aligned address with rsp_err=0.

Test Plan:
1. WAIT_STATES=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 edges after each acceptance.
2. Store byte 0x80 @0x13; load signed byte @0x13 -> 0xFFFFFF80; unsigned byte -> 0x00000080; load word @0x10 -> 0x80ADBEEF; signed half @0x12 -> 0xFFFF80AD.
3. Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid=1, rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next edge, req_ready=1.
4. DEPTH_WORDS=1024: store @0x1000 -> rsp_err=1, rsp_rdata=0; req_size=11 -> rsp_err=1; subsequent load @0x0 returns its previously written value unchanged.
5. Half load @0x11 -> with DMEM_MISALIGN_TRAP_EN: rsp_err=1, rdata=0; without: returns half from @0x10, rsp_err=0.
6. Assert rst during WAIT of a store of 0x12345678 @0x10 -> immediately rsp_valid=0, req_ready=1; after release, load @0x10 -> 0x80ADBEEF (store dropped).

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_STATES stall cycles, byte/half/word lanes.
// Optional macro DMEM_MISALIGN_TRAP_EN makes misaligned half/word accesses fault instead of aligning.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Request: req_ready=1 only in IDLE. Response: rsp_valid=1 only in RESP, data held until rsp_ready.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]   widx;
  logic [IW-1:0] mem_idx;
  logic          in_range;
  logic          bad;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   load_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          mem_we;

  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
    end
  end

  // Addresses below ADDR_BASE wrap to a huge index and fall out of range.
  assign widx     = 30'((addr_q - ADDR_BASE) >> 2);
  assign in_range = ({2'b00, widx} < 32'(DEPTH_WORDS));
  assign mem_idx  = widx[IW-1:0];
  assign rd_word  = mem[mem_idx];

  always_comb begin
    lane = addr_q[1:0];
    if (size_q == SZ_HALF) lane = {addr_q[1], 1'b0};
    if (size_q == SZ_WORD) lane = 2'b00;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                    ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  assign bad = (size_q == 2'b11) || !in_range || misalign;
`else
  assign bad = (size_q == 2'b11) || !in_range;
`endif

  always_comb begin
    ld_byte   = rd_word[{lane, 3'b000} +: 8];
    ld_half   = rd_word[{lane[1], 4'b0000} +: 16];
    load_data = rd_word;
    wr_word   = rd_word;
    case (size_q)
      SZ_BYTE: begin
        load_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        wr_word[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  // Array is not reset; the write is suppressed whenever rst is high.
  assign mem_we = (state_q == S_ACCESS) && we_q && !bad && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wr_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      rsp_err   <= bad;
      rsp_rdata <= (bad || we_q) ? 32'h0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (WAIT_STATES=1, DEPTH_WORDS=1024, ADDR_BASE=0).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request, waits for acceptance, then counts edges until rsp_valid.
  task automatic do_req(input vec_t v, output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic retire();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    vec_t v [2] = '{
      '{1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0}
    };
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 2; i++) begin
      do_req(v[i], rd, er, lat);
      retire();
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL word_lat[%0d]: got %0d want 2", i, lat); end
      n_checks++; if (rd !== v[i].exp_rdata) begin n_fail++; $display("FAIL word_rdata[%0d]: got %h want %h", i, rd, v[i].exp_rdata); end
      n_checks++; if (er !== v[i].exp_err) begin n_fail++; $display("FAIL word_err[%0d]: got %b want %b", i, er, v[i].exp_err); end
    end
  endtask

  task automatic test_byte_half();
    vec_t v [15] = '{
      '{1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h13, 32'h0,         2'b00, 1'b0, 32'hFFFF_FF80, 1'b0},
      '{1'b0, 32'h13, 32'h0,         2'b00, 1'b1, 32'h0000_0080, 1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 1'b0},
      '{1'b0, 32'h12, 32'h0,         2'b01, 1'b0, 32'hFFFF_80AD, 1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF, 1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0},
      '{1'b0, 32'h11, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFBE, 1'b0},
      '{1'b1, 32'h14, 32'h1122_3344, 2'b10, 1'b0, 32'h0,         1'b0},
      '{1'b1, 32'h14, 32'hAAAA_5566, 2'b01, 1'b0, 32'h0,         1'b0},
      '{1'b1, 32'h15, 32'h0000_0077, 2'b00, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h14, 32'h0,         2'b10, 1'b0, 32'h1122_7766, 1'b0},
      '{1'b0, 32'h16, 32'h0,         2'b01, 1'b1, 32'h0000_1122, 1'b0},
      '{1'b1, 32'h16, 32'hFFFF_9999, 2'b01, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h14, 32'h0,         2'b10, 1'b1, 32'h9999_7766, 1'b0}
    };
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 15; i++) begin
      do_req(v[i], rd, er, lat);
      retire();
      n_checks++; if (rd !== v[i].exp_rdata || er !== v[i].exp_err || lat !== 2) begin
        n_fail++;
        $display("FAIL lane[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=2", i, rd, er, lat, v[i].exp_rdata, v[i].exp_err);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t ld = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80AD_BEEF, 1'b0};
    logic [31:0] rd; logic er; int lat;
    do_req(ld, rd, er, lat);
    n_checks++; if (rd !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL bp_first_rdata: got %h want 80adbeef", rd); end
    // A stray store presented while the response is stalled must be ignored.
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = 2'b10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80AD_BEEF || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b want 1 80adbeef 0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    do_req(ld, rd, er, lat);
    retire();
    n_checks++; if (rd !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL bp_stray_ignored: got %h want 80adbeef", rd); end
  endtask

  task automatic test_errors();
    vec_t v [9] = '{
      '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0,         1'b0},
      '{1'b1, 32'h0000_1000, 32'h1111_1111, 2'b10, 1'b0, 32'h0,         1'b1},
      '{1'b0, 32'h0000_1000, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1},
      '{1'b1, 32'h0000_0000, 32'h0,         2'b11, 1'b0, 32'h0,         1'b1},
      '{1'b0, 32'h0000_0000, 32'h0,         2'b11, 1'b0, 32'h0,         1'b1},
      '{1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 2'b10, 1'b0, 32'h0,         1'b1},
      '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 2'b10, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h0000_0FFC, 32'h0,         2'b10, 1'b0, 32'h5A5A_5A5A, 1'b0},
      '{1'b0, 32'h0000_0000, 32'h0,         2'b10, 1'b0, 32'hCAFE_F00D, 1'b0}
    };
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 9; i++) begin
      do_req(v[i], rd, er, lat);
      retire();
      n_checks++; if (rd !== v[i].exp_rdata || er !== v[i].exp_err || lat !== 2) begin
        n_fail++;
        $display("FAIL err[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=2", i, rd, er, lat, v[i].exp_rdata, v[i].exp_err);
      end
    end
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
    vec_t v [5] = '{
      '{1'b0, 32'h11, 32'h0,         2'b01, 1'b1, 32'h0,         1'b1},
      '{1'b0, 32'h13, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1},
      '{1'b1, 32'h15, 32'h0000_4321, 2'b01, 1'b0, 32'h0,         1'b1},
      '{1'b0, 32'h14, 32'h0,         2'b10, 1'b0, 32'h9999_7766, 1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 1'b0}
    };
`else
    vec_t v [5] = '{
      '{1'b0, 32'h11, 32'h0,         2'b01, 1'b1, 32'h0000_BEEF, 1'b0},
      '{1'b0, 32'h13, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 1'b0},
      '{1'b1, 32'h15, 32'h0000_4321, 2'b01, 1'b0, 32'h0,         1'b0},
      '{1'b0, 32'h14, 32'h0,         2'b10, 1'b0, 32'h9999_4321, 1'b0},
      '{1'b0, 32'h10, 32'h0,         2'b10, 1'b0, 32'h80AD_BEEF, 1'b0}
    };
`endif
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 5; i++) begin
      do_req(v[i], rd, er, lat);
      retire();
      n_checks++; if (rd !== v[i].exp_rdata || er !== v[i].exp_err || lat !== 2) begin
        n_fail++;
        $display("FAIL misalign[%0d]: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=2", i, rd, er, lat, v[i].exp_rdata, v[i].exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t ld = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80AD_BEEF, 1'b0};
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_wait: req_ready got %b want 0", req_ready); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(ld, rd, er, lat);
    retire();
    n_checks++; if (rd !== 32'h80AD_BEEF || er !== 1'b0 || lat !== 2) begin
      n_fail++; $display("FAIL rstmid_dropped: got rdata=%h err=%b lat=%0d want 80adbeef 0 2", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_backpressure();
    test_errors();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
